serv_seq: RTL

Bit-serial instruction sequencer for the SERV core. It waits for an instruction fetch to complete, then drives the 32-cycle enable windows that step the serial PC/ALU datapath: an optional INIT pass, an optional data-bus wait, and the final RUN pass that updates the PC. It sits between the decoder and the control/PC datapath and owns the 5-bit bit counter shared by all serial units.

---
 rtl/serv_seq_pkg.sv | 14 +
 rtl/serv_seq_cnt.sv | 29 ++
 rtl/serv_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serv_seq_pkg.sv
// Shared types and constants for the SERV bit-serial sequencer.
package serv_seq_pkg;

    localparam int SEQ_CNT_W    = 5;
    localparam int SEQ_CNT_LAST = (1 << SEQ_CNT_W) - 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        INIT  = 2'd1,
        MEM   = 2'd2,
        RUN   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/serv_seq_cnt.sv
// Bit counter shared by all serial units: counts while enabled, wraps naturally
// from all-ones to zero, and is held at zero while cleared.
module serv_seq_cnt
    import serv_seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= o_cnt + CNT_ONE;
        end
    end

    assign o_last = (o_cnt == CNT_LAST);

endmodule

// File: rtl/serv_seq.sv
// SERV instruction sequencer: FETCH -> [INIT] -> [MEM] -> RUN serial passes.
// Trap capture (i_trap_req, i_misalign, o_trap) exists only with SERV_SEQ_TRAP_EN.
module serv_seq
    import serv_seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_ibus_ack,
    input  logic             i_two_stage,
    input  logic             i_mem_op,
    input  logic             i_trap_req,
    input  logic             i_misalign,
    input  logic             i_dbus_ack,
    output logic             o_en,
    output logic             o_pc_en,
    output logic             o_init,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_done,
    output logic             o_dbus_cyc,
    output logic             o_trap
);

    seq_state_t state;
    logic       two_stage_q;
    logic       mem_op_q;
    logic       trap_q;
    logic       cnt_last;
    logic       fetch_trap;
    logic       init_trap;

`ifdef SERV_SEQ_TRAP_EN
    assign fetch_trap = i_trap_req;
    assign init_trap  = trap_q | i_misalign;
`else
    logic unused_trap_inputs;
    assign unused_trap_inputs = i_trap_req | i_misalign;
    assign fetch_trap = 1'b0;
    assign init_trap  = 1'b0;
`endif

    // The counter runs exactly when the datapath is enabled, so it sits at 0
    // through FETCH and MEM and wraps on its own at the end of each pass.
    serv_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_en   (o_en),
        .i_clr  (!o_en),
        .o_cnt  (o_cnt),
        .o_last (cnt_last)
    );

    assign o_cnt_done = o_en & cnt_last;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= FETCH;
            two_stage_q <= 1'b0;
            mem_op_q    <= 1'b0;
            trap_q      <= 1'b0;
            o_en        <= 1'b0;
            o_pc_en     <= 1'b0;
            o_init      <= 1'b0;
            o_dbus_cyc  <= 1'b0;
            o_trap      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (i_ibus_ack) begin
                        two_stage_q <= i_two_stage;
                        mem_op_q    <= i_mem_op;
                        trap_q      <= fetch_trap;
                        o_en        <= 1'b1;
                        // A trap entry never needs operand preparation.
                        if (i_two_stage && !fetch_trap) begin
                            state  <= INIT;
                            o_init <= 1'b1;
                        end else begin
                            state   <= RUN;
                            o_pc_en <= 1'b1;
                            o_trap  <= fetch_trap;
                        end
                    end
                end
                INIT: begin
                    if (cnt_last) begin
                        trap_q <= init_trap;
                        o_init <= 1'b0;
                        if (init_trap || !(mem_op_q && two_stage_q)) begin
                            state   <= RUN;
                            o_pc_en <= 1'b1;
                            o_trap  <= init_trap;
                        end else begin
                            state      <= MEM;
                            o_en       <= 1'b0;
                            o_dbus_cyc <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (i_dbus_ack) begin
                        state      <= RUN;
                        o_en       <= 1'b1;
                        o_pc_en    <= 1'b1;
                        o_dbus_cyc <= 1'b0;
                        o_trap     <= trap_q;
                    end
                end
                RUN: begin
                    if (cnt_last) begin
                        state       <= FETCH;
                        two_stage_q <= 1'b0;
                        mem_op_q    <= 1'b0;
                        trap_q      <= 1'b0;
                        o_en        <= 1'b0;
                        o_pc_en     <= 1'b0;
                        o_trap      <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
